processing_element: RTL and testbench

Weight-stationary multiply-accumulate cell, tiled ROW×COL inside the systolic array. Each cell holds one weight, multiplies the activation arriving from the west by that weight, and adds the partial sum arriving from the north. It forwards the activation east and either the partial sum or pass-through data south. All outputs are registered, giving a one-cycle hop between neighbouring cells.

---
 rtl/processing_element_if.sv | 25 ++
 rtl/processing_element.sv | 92 +++++++++
 tb/tb_processing_element.sv | 130 +++++++++++++
 3 files changed

// File: rtl/processing_element_if.sv
// Bus between a processing element and its array/controller: control strobes,
// north/west data in, and east/south/observation data out.
interface processing_element_if #(
    parameter int WIDTH = 8
);
    logic             ctrl_load_i;
    logic             ctrl_sum_out_i;
    logic             ctrl_ps_in_i;
    logic [WIDTH-1:0] north_i;
    logic [WIDTH-1:0] west_i;
    logic [WIDTH-1:0] east_o;
    logic [WIDTH-1:0] south_o;
    logic [WIDTH-1:0] weight_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output ctrl_load_i, ctrl_sum_out_i, ctrl_ps_in_i, north_i, west_i,
        input  east_o, south_o, weight_o, result_o
    );

    modport slave (
        input  ctrl_load_i, ctrl_sum_out_i, ctrl_ps_in_i, north_i, west_i,
        output east_o, south_o, weight_o, result_o
    );
endinterface

// File: rtl/processing_element.sv
// Weight-stationary MAC cell for a systolic array; all outputs registered.
// Define PE_SATURATE_EN to saturate product and sum instead of wrapping.
module processing_element #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    processing_element_if.slave  pe
);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    logic [WIDTH-1:0]   weight_q, weight_d;
    logic [WIDTH-1:0]   east_q,   east_d;
    logic [WIDTH-1:0]   south_q,  south_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   ps_s;
    logic [WIDTH-1:0]   mac_s;

    // Clamp a double-width product to the largest representable value.
    function automatic logic [WIDTH-1:0] sat_product(input logic [2*WIDTH-1:0] p);
        logic [WIDTH-1:0] res;
        if (p[2*WIDTH-1:WIDTH] != ZERO_W) begin
            res = ONES_W;
        end else begin
            res = p[WIDTH-1:0];
        end
        return res;
    endfunction

    // Add two WIDTH-bit operands, clamping on carry-out.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] res;
        full = {1'b0, a} + {1'b0, b};
        if (full[WIDTH]) begin
            res = ONES_W;
        end else begin
            res = full[WIDTH-1:0];
        end
        return res;
    endfunction

    // MAC datapath; uses the weight held before the current edge.
    always_comb begin
        product_s = {{WIDTH{1'b0}}, pe.west_i} * {{WIDTH{1'b0}}, weight_q};
        ps_s      = pe.ctrl_ps_in_i ? pe.north_i : ZERO_W;
`ifdef PE_SATURATE_EN
        mac_s     = sat_add(sat_product(product_s), ps_s);
`else
        mac_s     = product_s[WIDTH-1:0] + ps_s;
`endif
    end

    // Next-state selection; load wins over sum-out.
    always_comb begin
        weight_d = weight_q;
        south_d  = pe.north_i;
        east_d   = pe.west_i;
        result_d = mac_s;
        if (pe.ctrl_load_i) begin
            weight_d = pe.north_i;
            south_d  = pe.north_i;
        end else if (pe.ctrl_sum_out_i) begin
            south_d  = mac_s;
        end else begin
            south_d  = pe.north_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weight_q <= ZERO_W;
            east_q   <= ZERO_W;
            south_q  <= ZERO_W;
            result_q <= ZERO_W;
        end else begin
            weight_q <= weight_d;
            east_q   <= east_d;
            south_q  <= south_d;
            result_q <= result_d;
        end
    end

    assign pe.weight_o = weight_q;
    assign pe.east_o   = east_q;
    assign pe.south_o  = south_q;
    assign pe.result_o = result_q;
endmodule

// File: tb/tb_processing_element.sv
// Directed testbench for processing_element (WIDTH=8) with hand-computed expectations.
module tb_processing_element;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    processing_element_if #(.WIDTH(8)) pe_bus ();

    processing_element #(.WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pe    (pe_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic so, input logic ps,
                         input logic [7:0] n, input logic [7:0] w);
        pe_bus.ctrl_load_i    = ld;
        pe_bus.ctrl_sum_out_i = so;
        pe_bus.ctrl_ps_in_i   = ps;
        pe_bus.north_i        = n;
        pe_bus.west_i         = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        step();

        // Reset with nonzero inputs and load asserted
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
        step();
        check_eq("rst_weight", pe_bus.weight_o, 8'd0);
        check_eq("rst_east",   pe_bus.east_o,   8'd0);
        check_eq("rst_south",  pe_bus.south_o,  8'd0);
        check_eq("rst_result", pe_bus.result_o, 8'd0);
        rst = 1'b0;

        // Load weight 3
        drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        step();
        check_eq("load3_weight", pe_bus.weight_o, 8'd3);
        check_eq("load3_south",  pe_bus.south_o,  8'd3);

        // Compute 5*3+7
        drive(1'b0, 1'b1, 1'b1, 8'd7, 8'd5);
        step();
        check_eq("mac_south",  pe_bus.south_o,  8'd22);
        check_eq("mac_result", pe_bus.result_o, 8'd22);
        check_eq("mac_east",   pe_bus.east_o,   8'd5);
        check_eq("mac_weight", pe_bus.weight_o, 8'd3);

        // Row-0 mode: weight 4, partial sum ignored
        drive(1'b1, 1'b0, 1'b0, 8'd4, 8'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'd99, 8'd6);
        step();
        check_eq("row0_south",  pe_bus.south_o,  8'd24);
        check_eq("row0_result", pe_bus.result_o, 8'd24);

        // Pass-through: result still tracks mac = 2*4+165
        drive(1'b0, 1'b0, 1'b1, 8'hA5, 8'd2);
        step();
        check_eq("pass_south",  pe_bus.south_o,  8'hA5);
        check_eq("pass_weight", pe_bus.weight_o, 8'd4);
        check_eq("pass_result", pe_bus.result_o, 8'd173);

        // Load priority over sum-out; result uses pre-edge weight 4
        drive(1'b1, 1'b1, 1'b0, 8'd9, 8'd1);
        step();
        check_eq("prio_weight", pe_bus.weight_o, 8'd9);
        check_eq("prio_south",  pe_bus.south_o,  8'd9);
        check_eq("prio_result", pe_bus.result_o, 8'd4);

        // Product overflow: 20*20+10
        drive(1'b1, 1'b0, 1'b0, 8'd20, 8'd0);
        step();
        drive(1'b0, 1'b1, 1'b1, 8'd10, 8'd20);
        step();
`ifdef PE_SATURATE_EN
        check_eq("ovf_result", pe_bus.result_o, 8'd255);
        check_eq("ovf_south",  pe_bus.south_o,  8'd255);
`else
        check_eq("ovf_result", pe_bus.result_o, 8'd154);
        check_eq("ovf_south",  pe_bus.south_o,  8'd154);
`endif

        // Sum-only overflow: 12*20=240 plus 30
        drive(1'b0, 1'b1, 1'b1, 8'd30, 8'd12);
        step();
`ifdef PE_SATURATE_EN
        check_eq("sumovf_result", pe_bus.result_o, 8'd255);
`else
        check_eq("sumovf_result", pe_bus.result_o, 8'd14);
`endif

        // Mid-operation reset discards the weight
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
        step();
        check_eq("midrst_weight", pe_bus.weight_o, 8'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'd50, 8'd7);
        step();
        check_eq("midrst_result", pe_bus.result_o, 8'd0);
        check_eq("midrst_east",   pe_bus.east_o,   8'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
